st7735_spi_tx: RTL and testbench

Byte-level 4-wire SPI transmitter for the ST7735 panel. It sits directly downstream of the LCD init/pixel controller. The controller hands it one byte at a time plus a D/C flag over a valid/ready handshake. The block serialises each byte MSB-first onto CS/MOSI/DC/LCD_CLK with programmable SCK rate and CS framing, so the controller no longer bit-bangs pins itself.

---
 rtl/st7735_pkg.sv | 26 ++
 rtl/st7735_sck_tick.sv | 31 +++
 rtl/st7735_spi_tx.sv | 170 +++++++++++++++++
 tb/tb_st7735_spi_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/st7735_pkg.sv
// Shared types and constants for the ST7735 byte-level SPI transmitter.
package st7735_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StGap
  } state_e;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // Pin levels while no byte is framed (mode 3: SCK idles high).
  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCK_IDLE  = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;
  localparam logic DC_IDLE   = DC_DATA;

  // A phase of N cycles loads N-1 and advances when the counter reads zero.
  function automatic logic [7:0] phase_reload(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/st7735_sck_tick.sv
// Reloadable 8-bit half-period down-counter; expire marks the last cycle of a phase.
module st7735_sck_tick (
  input  logic       SYSTEM_CLK,
  input  logic       SYSTEM_RST,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       expire_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RST) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 8'd0);

endmodule

// File: rtl/st7735_spi_tx.sv
// ST7735 4-wire SPI byte transmitter (mode 3, MSB first) with a one-byte holding register.
// Define ST7735_CS_BURST_EN to keep CS low across back-to-back bytes.
module st7735_spi_tx
  import st7735_pkg::*;
#(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int SCK_DIV         = 2,
  parameter int CS_GAP_CYCLES   = 2
) (
  input  logic       SYSTEM_CLK,
  input  logic       SYSTEM_RST,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       CS,
  output logic       MOSI,
  output logic       DC,
  output logic       LCD_CLK
);

  if (CLOCK_SPEED_MHZ < 1 || SCK_DIV < 1 || SCK_DIV > 255 ||
      CS_GAP_CYCLES < 1 || CS_GAP_CYCLES > 255) begin : g_bad_cfg
    $error("st7735_spi_tx: illegal SCK_DIV/CS_GAP_CYCLES configuration");
  end

  localparam logic [7:0] SckReload = phase_reload(SCK_DIV);
  localparam logic [7:0] GapReload = phase_reload(CS_GAP_CYCLES);

  state_e     state_q, state_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_dc_q, hold_dc_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       dc_q, dc_d;
  logic       cs_q, cs_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       ready_en_q;
  logic       take, accept, framed, expire, tick_load;
  logic [7:0] tick_reload;

  st7735_sck_tick u_sck_tick (
    .SYSTEM_CLK (SYSTEM_CLK),
    .SYSTEM_RST (SYSTEM_RST),
    .load_i     (tick_load),
    .load_val_i (tick_reload),
    .expire_o   (expire)
  );

  assign tx_ready = ready_en_q && !hold_full_q;
  assign accept   = tx_valid && tx_ready;
  assign busy     = hold_full_q || (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    dc_d      = dc_q;
    take      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          take    = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (expire) begin
          state_d   = StLow;
          bit_idx_d = 3'd7;
        end
      end
      StLow: begin
        if (expire) state_d = StHigh;
      end
      StHigh: begin
        if (expire) begin
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            state_d   = StLow;
`ifdef ST7735_CS_BURST_EN
          end else if (hold_full_q) begin
            take      = 1'b1;
            bit_idx_d = 3'd7;
            state_d   = StLow;
`endif
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        // Idle's pickup is folded in so a queued byte sees exactly the CS gap.
        if (expire) begin
          if (hold_full_q) begin
            take    = 1'b1;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      shift_d = hold_data_q;
      dc_d    = hold_dc_q;
    end
  end

  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_dc_d   = hold_dc_q;
    if (take) hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
      hold_dc_d   = tx_dc;
    end
  end

  // Pins are registered from the next state so they change cleanly with it.
  always_comb begin
    framed      = (state_d == StSetup) || (state_d == StLow) || (state_d == StHigh);
    cs_d        = framed ? 1'b0 : CS_IDLE;
    sck_d       = (state_d == StLow) ? 1'b0 : SCK_IDLE;
    mosi_d      = framed ? shift_d[7] : MOSI_IDLE;
    tick_load   = (state_d != state_q);
    tick_reload = (state_d == StGap) ? GapReload : SckReload;
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RST) begin
      state_q     <= StIdle;
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
      hold_dc_q   <= DC_IDLE;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      dc_q        <= DC_IDLE;
      cs_q        <= CS_IDLE;
      sck_q       <= SCK_IDLE;
      mosi_q      <= MOSI_IDLE;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_dc_q   <= hold_dc_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      dc_q        <= dc_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign CS      = cs_q;
  assign MOSI    = mosi_q;
  assign DC      = dc_q;
  assign LCD_CLK = sck_q;

endmodule

// File: tb/tb_st7735_spi_tx.sv
// Directed bench for st7735_spi_tx: three instances (SCK_DIV 2, 1, 3) observed by a pin monitor.
module tb_st7735_spi_tx;
  import st7735_pkg::*;

  localparam int DIV [3] = '{2, 1, 3};

  logic       SYSTEM_CLK = 1'b0;
  logic       SYSTEM_RST = 1'b1;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_dc      = 1'b0;
  logic       tx_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic       tx_ready [3];
  logic       busy [3];
  logic       cs [3];
  logic       mosi [3];
  logic       dc [3];
  logic       sck [3];

  int vectors = 0;
  int miscompares = 0;

  logic        clr = 1'b0;
  int          edges [3], cs_run [3], last_run [3], gap_run [3], last_gap [3];
  int          lo_run [3], hi_run [3], bad_phase [3], unstable [3];
  int          dc_hi [3], mosi_lo_ones [3];
  logic [15:0] bits [3], dcs [3];
  logic        prev_sck [3], prev_cs [3], prev_mosi [3], prev_dc [3];

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  st7735_spi_tx #(.CLOCK_SPEED_MHZ(12), .SCK_DIV(2), .CS_GAP_CYCLES(2)) u_dut_div2 (
    .SYSTEM_CLK(SYSTEM_CLK), .SYSTEM_RST(SYSTEM_RST), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .busy(busy[0]), .CS(cs[0]),
    .MOSI(mosi[0]), .DC(dc[0]), .LCD_CLK(sck[0]));

  st7735_spi_tx #(.CLOCK_SPEED_MHZ(12), .SCK_DIV(1), .CS_GAP_CYCLES(2)) u_dut_div1 (
    .SYSTEM_CLK(SYSTEM_CLK), .SYSTEM_RST(SYSTEM_RST), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .busy(busy[1]), .CS(cs[1]),
    .MOSI(mosi[1]), .DC(dc[1]), .LCD_CLK(sck[1]));

  st7735_spi_tx #(.CLOCK_SPEED_MHZ(12), .SCK_DIV(3), .CS_GAP_CYCLES(2)) u_dut_div3 (
    .SYSTEM_CLK(SYSTEM_CLK), .SYSTEM_RST(SYSTEM_RST), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .busy(busy[2]), .CS(cs[2]),
    .MOSI(mosi[2]), .DC(dc[2]), .LCD_CLK(sck[2]));

  // Pin monitor, sampled mid-cycle.
  always @(negedge SYSTEM_CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        edges[i] = 0; cs_run[i] = 0; last_run[i] = 0; gap_run[i] = 0; last_gap[i] = 0;
        lo_run[i] = 0; hi_run[i] = 0; bad_phase[i] = 0; unstable[i] = 0;
        dc_hi[i] = 0; mosi_lo_ones[i] = 0; bits[i] = '0; dcs[i] = '0;
      end else begin
        if (!prev_sck[i] && sck[i]) begin
          edges[i]++;
          bits[i] = {bits[i][14:0], mosi[i]};
          dcs[i]  = {dcs[i][14:0], dc[i]};
          if (mosi[i] !== prev_mosi[i] || dc[i] !== prev_dc[i]) unstable[i]++;
          if (lo_run[i] != DIV[i]) bad_phase[i]++;
          lo_run[i] = 0;
        end
        if (prev_sck[i] && !sck[i] && !prev_cs[i]) begin
          if (hi_run[i] != DIV[i]) bad_phase[i]++;
          hi_run[i] = 0;
        end
        if (!prev_cs[i] && cs[i]) begin
          last_run[i] = cs_run[i];
          cs_run[i] = 0;
          if (hi_run[i] != DIV[i]) bad_phase[i]++;
          hi_run[i] = 0;
        end
        if (prev_cs[i] && !cs[i]) begin
          last_gap[i] = gap_run[i];
          gap_run[i] = 0;
        end
        if (!cs[i]) begin
          cs_run[i]++;
          if (!sck[i]) lo_run[i]++; else hi_run[i]++;
          if (dc[i]) dc_hi[i]++;
          if (!sck[i] && mosi[i]) mosi_lo_ones[i]++;
        end else begin
          gap_run[i]++;
        end
      end
      prev_sck[i] = sck[i]; prev_cs[i] = cs[i]; prev_mosi[i] = mosi[i]; prev_dc[i] = dc[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge SYSTEM_CLK);
      #1;
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic dcv, input bit release_v);
    int waited = 0;
    tx_data = data;
    tx_dc = dcv;
    tx_valid[d] = 1'b1;
    while (tx_ready[d] !== 1'b1 && waited < 500) begin
      tick();
      waited++;
    end
    check("send_ready", 32'(tx_ready[d]), 32'd1);
    tick();
    if (release_v) tx_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int waited = 0;
    while (busy[d] !== 1'b0 && waited < 2000) begin
      tick();
      waited++;
    end
    check("idle_reached", 32'(busy[d]), 32'd0);
    tick(3);
  endtask

  initial begin
    int waited;
    // Reset state
    tick(3);
    check("rst_cs", 32'(cs[0]), 32'd1);
    check("rst_sck", 32'(sck[0]), 32'd1);
    check("rst_mosi", 32'(mosi[0]), 32'd0);
    check("rst_dc", 32'(dc[0]), 32'd1);
    check("rst_ready", 32'(tx_ready[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    SYSTEM_RST = 1'b0;
    check("ready_before_edge", 32'(tx_ready[1]), 32'd0);
    tick();
    check("ready_after_rst", 32'(tx_ready[1]), 32'd1);
    tick(2);

    // Command 0x11 at SCK_DIV=2
    clear_mon();
    send(0, 8'h11, DC_CMD, 1'b1);
    wait_idle(0);
    check("t1_edges", 32'(edges[0]), 32'd8);
    check("t1_bits", 32'(bits[0][7:0]), 32'h11);
    check("t1_dc_edges", 32'(dcs[0][7:0]), 32'h00);
    check("t1_dc_low", 32'(dc_hi[0]), 32'd0);
    check("t1_cs_low", 32'(last_run[0]), 32'd34);
    check("t1_stable", 32'(unstable[0]), 32'd0);
    check("t1_cs_gap", 32'(gap_run[0] >= 2), 32'd1);

    // Parameter 0xA5 at SCK_DIV=1
    clear_mon();
    send(1, 8'hA5, DC_DATA, 1'b1);
    wait_idle(1);
    check("t2_edges", 32'(edges[1]), 32'd8);
    check("t2_bits", 32'(bits[1][7:0]), 32'hA5);
    check("t2_dc_edges", 32'(dcs[1][7:0]), 32'hFF);
    check("t2_cs_low", 32'(last_run[1]), 32'd17);
    check("t2_stable", 32'(unstable[1]), 32'd0);

    // Back-to-back 0x2A (cmd) then 0x00 (data), valid held throughout
    clear_mon();
    send(0, 8'h2A, DC_CMD, 1'b0);
    send(0, 8'h00, DC_DATA, 1'b1);
    check("t3_second_during_first", 32'(cs[0]), 32'd0);
    check("t3_ready_low", 32'(tx_ready[0]), 32'd0);
    tick(10);
    check("t3_ready_still_low", 32'(tx_ready[0]), 32'd0);
    wait_idle(0);
    check("t3_edges", 32'(edges[0]), 32'd16);
    check("t3_bits", 32'(bits[0]), 32'h2A00);
    check("t3_dc_edges", 32'(dcs[0]), 32'h00FF);
    check("t3_stable", 32'(unstable[0]), 32'd0);
`ifdef ST7735_CS_BURST_EN
    check("t3_cs_continuous", 32'(last_run[0]), 32'd66);
`else
    check("t3_cs_low", 32'(last_run[0]), 32'd34);
    check("t3_cs_gap", 32'(last_gap[0]), 32'd2);
`endif

    // Reset after the third rising edge of 0xFF
    clear_mon();
    send(0, 8'hFF, DC_DATA, 1'b1);
    waited = 0;
    while (edges[0] < 3 && waited < 500) begin
      tick();
      waited++;
    end
    check("t4_edges_before", 32'(edges[0]), 32'd3);
    SYSTEM_RST = 1'b1;
    tick();
    check("t4_cs", 32'(cs[0]), 32'd1);
    check("t4_sck", 32'(sck[0]), 32'd1);
    check("t4_mosi", 32'(mosi[0]), 32'd0);
    check("t4_dc", 32'(dc[0]), 32'd1);
    check("t4_busy", 32'(busy[0]), 32'd0);
    tick();
    SYSTEM_RST = 1'b0;
    check("t4_ready_in_rst", 32'(tx_ready[0]), 32'd0);
    tick();
    check("t4_ready_after", 32'(tx_ready[0]), 32'd1);
    tick(20);
    check("t4_no_more_edges", 32'(edges[0]), 32'd3);

    // Holding register must not be overwritten while full
    clear_mon();
    send(0, 8'h3C, DC_DATA, 1'b1);
    send(0, 8'hC3, DC_CMD, 1'b1);
    tx_data = 8'h77;
    tx_dc = DC_DATA;
    tx_valid[0] = 1'b1;
    tick();
    check("t5_ready_full", 32'(tx_ready[0]), 32'd0);
    tick(8);
    check("t5_ready_full_later", 32'(tx_ready[0]), 32'd0);
    tx_valid[0] = 1'b0;
    wait_idle(0);
    check("t5_edges", 32'(edges[0]), 32'd16);
    check("t5_bits", 32'(bits[0]), 32'h3CC3);
    check("t5_dc_edges", 32'(dcs[0]), 32'hFF00);

    // 0x80 at SCK_DIV=3
    clear_mon();
    send(2, 8'h80, DC_DATA, 1'b1);
    wait_idle(2);
    check("t6_edges", 32'(edges[2]), 32'd8);
    check("t6_bits", 32'(bits[2][7:0]), 32'h80);
    check("t6_phase_len", 32'(bad_phase[2]), 32'd0);
    check("t6_mosi_low_ones", 32'(mosi_lo_ones[2]), 32'd3);
    check("t6_cs_low", 32'(last_run[2]), 32'd51);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
